// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Single outstanding request; a transfer completes when req and ack are both high.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and drives the IF/ID register with stall, skid-buffer, bubble and redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_if,
    input  logic               stall_d,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic               d_valid,
    output logic [31:0]        d_instr,
    output logic [31:0]        d_pc,
    output logic [31:0]        d_pc4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        issue;
    logic        xfer;
    logic        keep_ack;

    // A fresh request leaves IDLE combinationally so a zero-wait memory sustains one fetch per cycle.
    assign issue = (state == S_IDLE) && rst_n && !stall_if && !skid_valid && !redirect_valid;

    assign imem.imem_req  = issue || (state != S_IDLE);
    assign imem.imem_addr = (state == S_IDLE) ? pc : req_addr;

    assign xfer     = imem.imem_req && imem.imem_ack;
    assign keep_ack = xfer && (state != S_DROP) && !redirect_valid;

    assign d_pc4 = d_pc + 32'd4;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE: if (issue && !imem.imem_ack) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem.imem_ack)       state_nxt = S_IDLE;
                else if (redirect_valid) state_nxt = S_DROP;
            end
            S_DROP: if (imem.imem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            skid_valid <= 1'b0;
            d_valid    <= 1'b0;
            d_instr    <= 32'h0;
            d_pc       <= 32'h0;
        end else begin
            state <= state_nxt;

            if (redirect_valid)
                pc <= redirect_pc;
            else if (keep_ack)
                pc <= imem.imem_addr + 32'd4;

            if (redirect_valid) begin
                d_valid    <= 1'b0;
                d_instr    <= 32'h0;
                skid_valid <= 1'b0;
            end else if (stall_d) begin
                if (keep_ack) skid_valid <= 1'b1;
            end else if (skid_valid) begin
                d_valid    <= 1'b1;
                d_instr    <= skid_instr;
                d_pc       <= skid_pc;
                skid_valid <= 1'b0;
            end else if (keep_ack) begin
                d_valid <= 1'b1;
                d_instr <= imem.imem_rdata;
                d_pc    <= imem.imem_addr;
            end else begin
                d_valid <= 1'b0;
                d_instr <= 32'h0;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only observed behind a reset valid bit or state.
    always_ff @(posedge clk) begin
        if (issue) req_addr <= pc;
        if (!redirect_valid && stall_d && keep_ack) begin
            skid_instr <= imem.imem_rdata;
            skid_pc    <= imem.imem_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and slow memory, stalls with skid,
// redirects (in WAIT, with ack, with full buffer) and reset in the middle of a fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_if       (stall_if),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .d_valid        (d_valid),
        .d_instr        (d_instr),
        .d_pc           (d_pc),
        .d_pc4          (d_pc4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_if       = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    // Leaves the bench in the first cycle with rst_n=1, inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_req_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b0, 32'h0});
        end
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_ifid: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b0, 32'h0, 32'h0});
        end
        checks++;
        if (d_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc4: got %h expected %h", d_pc4, 32'h4);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        do_reset();
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.imem_rdata = 32'h1000_0000 + 32'(i);
            #1;
            exp_addr = 32'(i) * 32'd4;
            checks++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_addr}) begin
                errors++;
                $display("FAIL zw_addr[%0d]: got %h expected %h", i, {bus.imem_req, bus.imem_addr}, {1'b1, exp_addr});
            end
            if (i == 0) begin
                checks++;
                if (d_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL zw_first_bubble: got %b expected 0", d_valid);
                end
            end else begin
                exp_instr = 32'h1000_0000 + 32'(i - 1);
                checks++;
                if ({d_valid, d_instr, d_pc} !== {1'b1, exp_instr, exp_addr - 32'd4}) begin
                    errors++;
                    $display("FAIL zw_ifid[%0d]: got %h expected %h", i, {d_valid, d_instr, d_pc}, {1'b1, exp_instr, exp_addr - 32'd4});
                end
                checks++;
                if (d_pc4 !== exp_addr) begin
                    errors++;
                    $display("FAIL zw_pc4[%0d]: got %h expected %h", i, d_pc4, exp_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack   = (i == 3);
            bus.imem_rdata = (i == 3) ? 32'h2400_0001 : 32'hFFFF_FFFF;
            #1;
            checks++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL lat_addr_stable[%0d]: got %h expected %h", i, {bus.imem_req, bus.imem_addr}, {1'b1, 32'h0});
            end
            checks++;
            if ({d_valid, d_instr, d_pc} !== {1'b0, 32'h0, 32'h0}) begin
                errors++;
                $display("FAIL lat_bubble[%0d]: got %h expected %h", i, {d_valid, d_instr, d_pc}, {1'b0, 32'h0, 32'h0});
            end
            tick();
        end
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h2400_0001, 32'h0}) begin
            errors++;
            $display("FAIL lat_deliver: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h2400_0001, 32'h0});
        end
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL lat_next_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h4});
        end
        tick();
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL lat_once: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b0, 32'h0, 32'h0});
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C01_0000;
        tick();
        stall_d = 1'b1;  bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL st_issue: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h4});
        end
        tick();
        stall_if = 1'b1;  bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C02_0004;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h8C01_0000, 32'h0}) begin
            errors++;
            $display("FAIL st_hold1: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h8C01_0000, 32'h0});
        end
        tick();
        bus.imem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL st_no_req: got %b expected 0", bus.imem_req);
        end
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h8C01_0000, 32'h0}) begin
            errors++;
            $display("FAIL st_hold2: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h8C01_0000, 32'h0});
        end
        tick();
        stall_if = 1'b0;  stall_d = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL st_full_no_req: got %b expected 0", bus.imem_req);
        end
        tick();
        bus.imem_rdata = 32'h8C03_0008;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h8C02_0004, 32'h4}) begin
            errors++;
            $display("FAIL st_from_skid: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h8C02_0004, 32'h4});
        end
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL st_resume_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h8});
        end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h8C03_0008, 32'h8}) begin
            errors++;
            $display("FAIL st_after: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h8C03_0008, 32'h8});
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C01_0000;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        redirect_valid = 1'b1;  redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rw_bubble: got %h expected %h", {d_valid, d_instr}, {1'b0, 32'h0});
        end
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL rw_addr_stable: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h4});
        end
        tick();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rdata = 32'h2000_0100;
        #1;
        checks++;
        if ({d_valid, d_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rw_dropped: got %h expected %h", {d_valid, d_instr}, {1'b0, 32'h0});
        end
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL rw_target_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h100});
        end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc, d_pc4} !== {1'b1, 32'h2000_0100, 32'h100, 32'h104}) begin
            errors++;
            $display("FAIL rw_target_ifid: got %h expected %h", {d_valid, d_instr, d_pc, d_pc4}, {1'b1, 32'h2000_0100, 32'h100, 32'h104});
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        tick();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'hDEAD_0000;
        redirect_valid = 1'b1;  redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;  bus.imem_rdata = 32'h2000_0200;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL ra_addr: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h200});
        end
        checks++;
        if ({d_valid, d_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL ra_discard: got %h expected %h", {d_valid, d_instr}, {1'b0, 32'h0});
        end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h2000_0200, 32'h200}) begin
            errors++;
            $display("FAIL ra_ifid: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h2000_0200, 32'h200});
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C01_0000;
        tick();
        stall_d = 1'b1;  bus.imem_ack = 1'b0;
        tick();
        stall_if = 1'b1;  bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C02_0004;
        tick();
        bus.imem_ack = 1'b0;  redirect_valid = 1'b1;  redirect_pc = 32'h0000_0300;
        tick();
        stall_if = 1'b0;  stall_d = 1'b0;  redirect_valid = 1'b0;
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h2000_0300;
        #1;
        checks++;
        if ({d_valid, d_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rs_bubble: got %h expected %h", {d_valid, d_instr}, {1'b0, 32'h0});
        end
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL rs_empty_target: got %h expected %h", {bus.imem_req, bus.imem_addr}, {1'b1, 32'h300});
        end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h2000_0300, 32'h300}) begin
            errors++;
            $display("FAIL rs_ifid: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h2000_0300, 32'h300});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.imem_ack = 1'b1;  bus.imem_rdata = 32'h8C01_0000;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr, d_valid, d_instr, d_pc, d_pc4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL rm_reset_vals: got %h expected %h", {bus.imem_req, bus.imem_addr, d_valid, d_instr, d_pc, d_pc4}, {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4});
        end
        tick();
        rst_n = 1'b1;  stall_if = 1'b1;  bus.imem_ack = 1'b1;  bus.imem_rdata = 32'hBAD0_0004;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rm_late_ack_req: got %b expected 0", bus.imem_req);
        end
        tick();
        stall_if = 1'b0;  bus.imem_rdata = 32'h2000_0000;
        #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr, d_valid, d_instr} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rm_restart: got %h expected %h", {bus.imem_req, bus.imem_addr, d_valid, d_instr}, {1'b1, 32'h0, 1'b0, 32'h0});
        end
        tick();
        bus.imem_ack = 1'b0;
        #1;
        checks++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h2000_0000, 32'h0}) begin
            errors++;
            $display("FAIL rm_ifid: got %h expected %h", {d_valid, d_instr, d_pc}, {1'b1, 32'h2000_0000, 32'h0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
